pd_header_assembler: RTL and testbench
======================================

// Module: pd_header_assembler
// PURPOSE
//  Assembles an 80-byte block header from a stream of 32-bit words into the
//  chunk1[511:0] / chunk2[127:0] pair consumed by PD_chunk_decoder.
//  Sits between the host word interface and the decoder; holds a complete
//  header stable, with header_valid asserted, until the hashing side acks it.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max idle cycles between accepted words in LOAD; 0 = timeout disabled
// PORTS
//  clk           in   1    system clock, rising edge
//  n_rst         in   1    asynchronous active-low reset
//  start         in   1    pulse: clear registers and begin loading a new header
//  word_in       in   32   header word, raw byte order (word0 = version)
//  word_valid    in   1    word_in valid
//  word_ready    out  1    block accepts word this cycle
//  chunk1        out  512  header words 0..15, word0 in [511:480]
//  chunk2        out  128  header words 16..19, word16 in [127:96], nonce in [31:0]
//  header_valid  out  1    chunk1/chunk2 hold a complete header
//  header_ack    in   1    consumer has taken the header
//  timeout_err   out  1    1-cycle pulse: load aborted by inter-word timeout
//  nonce_wrap    out  1    1-cycle pulse: nonce wrapped (tied 0 without PD_NONCE_INC_EN)
// BEHAVIOUR
//  Reset: state IDLE; chunk1, chunk2, word count, timeout count = 0;
//   word_ready, header_valid, timeout_err, nonce_wrap = 0.
//  Word accepted when word_valid && word_ready (same edge).
//  FSM states IDLE, LOAD, HOLD (+BUMP with macro); all outputs registered.
//  IDLE: word_ready=0. start -> chunk1/chunk2 cleared, count=0, go LOAD.
//  LOAD: word_ready=1. Accepted word idx k (0..19) written: k<16 ->
//   chunk1[511-32k -: 32]; k>=16 -> chunk2[127-32(k-16) -: 32]; count++.
//   Accepting word 19 -> HOLD; header_valid=1 the cycle after that word.
//  Timeout: in LOAD, counter increments each cycle with no accepted word and
//   clears on accept; reaching TIMEOUT_CYCLES -> IDLE, chunks cleared,
//   timeout_err pulsed 1 cycle.
//  start in LOAD: restart (clear chunks, count=0, stay LOAD); start beats a
//   simultaneous word (word dropped, word_ready must be treated as 0).
//  HOLD: word_ready=0, header_valid=1, chunks stable. header_ack -> IDLE,
//   header_valid=0 next cycle, chunks retained. start in HOLD without ack
//   ignored; start with ack -> clear and go LOAD directly.
//  header_ack outside HOLD ignored. word_valid outside LOAD ignored.
//  n_rst low at any time (mid-load included) -> immediate reset values.
// CONFIGURATION
//  PD_NONCE_INC_EN defined: header_ack in HOLD does not exit; nonce field
//   chunk2[31:0] is treated as little-endian: byte-swap, +1 (mod 2^32),
//   byte-swap back, written in BUMP; header_valid=0 for exactly one cycle
//   (BUMP) then HOLD with header_valid=1. If the LE value was 0xFFFFFFFF:
//   field becomes 0, nonce_wrap pulses, go IDLE instead of HOLD.
//   HOLD exits via start (clear, go LOAD) or reset.
//  PD_NONCE_INC_EN undefined: no BUMP state, ack -> IDLE, nonce_wrap=0.
// TESTING
//  1 start, 20 back-to-back words (w0=0x01000000 .. w19=0x0f2b5710) ->
//    chunk1[511:480]=0x01000000, chunk2[31:0]=0x0f2b5710, header_valid=1 the
//    cycle after w19, word_ready=0 in HOLD.
//  2 same header, word_valid toggled every other cycle, 3-cycle gaps ->
//    identical chunks; header_valid only after 20th accept; no timeout_err.
//  3 TIMEOUT_CYCLES=8, stop after 5 words -> timeout_err pulse 8 cycles
//    after last accept, state IDLE, chunks=0, word_ready=0.
//  4 start asserted after 10 words, then 20 new words -> chunks contain only
//    new words; header_valid after 20th new word; ack -> header_valid=0 next cycle.
//  5 n_rst low mid-load (word 7) and in HOLD -> all outputs 0 immediately;
//    header_ack/word_valid in IDLE have no effect.
//  6 PD_NONCE_INC_EN, chunk2[31:0]=0x0f2b5710, ack -> one cycle
//    header_valid=0, then chunk2[31:0]=0x102b5710, valid=1; preload
//    0xffffffff, ack -> field 0, nonce_wrap pulse, IDLE.

Source files
------------

// File: rtl/pd_header_assembler.sv
// pd_header_assembler: packs 20 header words into chunk1/chunk2 and holds them until acked.
// Define PD_NONCE_INC_EN to make ack bump the little-endian nonce in place instead of releasing.
module pd_header_assembler #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         start,
    input  logic [31:0]  word_in,
    input  logic         word_valid,
    output logic         word_ready,
    output logic [511:0] chunk1,
    output logic [127:0] chunk2,
    output logic         header_valid,
    input  logic         header_ack,
    output logic         timeout_err,
    output logic         nonce_wrap
);
`ifdef PD_NONCE_INC_EN
    typedef enum logic [1:0] {IDLE, LOAD, HOLD, BUMP} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
`endif
    state_t      state, state_nxt;
    logic [4:0]  cnt;
    logic [31:0] tcnt;
    logic        accept, clear, tmo, wrap;
`ifdef PD_NONCE_INC_EN
    logic        bump;
    logic [31:0] le, inc, nonce_nxt;
    assign le        = {chunk2[7:0], chunk2[15:8], chunk2[23:16], chunk2[31:24]};
    assign inc       = le + 32'd1;
    assign nonce_nxt = {inc[7:0], inc[15:8], inc[23:16], inc[31:24]};
`endif
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        clear     = 1'b0;
        tmo       = 1'b0;
        wrap      = 1'b0;
`ifdef PD_NONCE_INC_EN
        bump      = 1'b0;
`endif
        case (state)
            IDLE: if (start) begin
                state_nxt = LOAD;
                clear     = 1'b1;
            end
            // start wins over a word arriving on the same edge
            LOAD: if (start) clear = 1'b1;
            else if (word_valid) begin
                accept = 1'b1;
                if (cnt == 5'd19) state_nxt = HOLD;
            end else if (TIMEOUT_CYCLES != 0 && tcnt == TIMEOUT_CYCLES - 1) begin
                tmo       = 1'b1;
                clear     = 1'b1;
                state_nxt = IDLE;
            end
`ifdef PD_NONCE_INC_EN
            HOLD: if (start) begin
                clear     = 1'b1;
                state_nxt = LOAD;
            end else if (header_ack) state_nxt = BUMP;
            BUMP: begin
                bump      = 1'b1;
                wrap      = &le;
                state_nxt = (&le) ? IDLE : HOLD;
            end
`else
            HOLD: if (header_ack) begin
                clear     = start;
                state_nxt = start ? LOAD : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            chunk1       <= '0;
            chunk2       <= '0;
            cnt          <= '0;
            tcnt         <= '0;
            word_ready   <= 1'b0;
            header_valid <= 1'b0;
            timeout_err  <= 1'b0;
            nonce_wrap   <= 1'b0;
        end else begin
            state        <= state_nxt;
            word_ready   <= state_nxt == LOAD;
            header_valid <= state_nxt == HOLD;
            timeout_err  <= tmo;
            nonce_wrap   <= wrap;
            tcnt         <= (state == LOAD && !accept && !clear) ? tcnt + 32'd1 : '0;
            if (clear) begin
                chunk1 <= '0;
                chunk2 <= '0;
                cnt    <= '0;
            end else if (accept) begin
                // word k lands MSB-first: slot index 15-k (chunk1) or 3-(k-16) (chunk2)
                if (cnt[4]) chunk2[{~cnt[1:0], 5'd0} +: 32] <= word_in;
                else chunk1[{~cnt[3:0], 5'd0} +: 32] <= word_in;
                cnt <= cnt + 5'd1;
            end
`ifdef PD_NONCE_INC_EN
            else if (bump) chunk2[31:0] <= nonce_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_pd_header_assembler.sv
// tb_pd_header_assembler: directed checks of header loading, timeout, restart, reset and ack handling.
// Nonce-bump checks are compiled in when PD_NONCE_INC_EN is defined.
module tb_pd_header_assembler;
    logic         tb_clk = 1'b0;
    logic         n_rst, start, word_valid, word_ready, header_valid, header_ack;
    logic         timeout_err, nonce_wrap;
    logic [31:0]  word_in;
    logic [511:0] chunk1;
    logic [127:0] chunk2;
    logic [31:0]  cur [20];
    int           tests = 0;
    int           fails = 0;

    always #5 tb_clk = ~tb_clk;

    pd_header_assembler #(.TIMEOUT_CYCLES(8)) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start), .word_in(word_in),
        .word_valid(word_valid), .word_ready(word_ready), .chunk1(chunk1),
        .chunk2(chunk2), .header_valid(header_valid), .header_ack(header_ack),
        .timeout_err(timeout_err), .nonce_wrap(nonce_wrap)
    );

    task automatic tick();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic base_hdr();
        for (int k = 0; k < 20; k++) cur[k] = 32'h9e3779b9 * k;
        cur[0]  = 32'h01000000;
        cur[19] = 32'h0f2b5710;
    endtask

    task automatic feed(input int n);
        for (int k = 0; k < n; k++) begin
            word_valid = 1'b1;
            word_in    = cur[k];
            tick();
        end
        word_valid = 1'b0;
    endtask

    function automatic logic [511:0] exp1();
        logic [511:0] r = '0;
        for (int k = 0; k < 16; k++) r = {r[479:0], cur[k]};
        return r;
    endfunction

    function automatic logic [511:0] exp2();
        logic [127:0] r = '0;
        for (int k = 16; k < 20; k++) r = {r[95:0], cur[k]};
        return 512'(r);
    endfunction

    initial begin
        n_rst = 1'b0; start = 1'b0; word_valid = 1'b0; header_ack = 1'b0; word_in = '0;
        base_hdr();
        tick(); tick();
        chk1("rst_ready", word_ready, 1'b0);
        chk1("rst_valid", header_valid, 1'b0);
        chkw("rst_c1", chunk1, '0);
        chkw("rst_c2", 512'(chunk2), '0);
        chk1("rst_tmo", timeout_err, 1'b0);
        chk1("rst_wrap", nonce_wrap, 1'b0);
        n_rst = 1'b1;
        tick();
        // ack and words while idle do nothing
        header_ack = 1'b1; word_valid = 1'b1; word_in = 32'hdeadbeef;
        tick(); tick();
        chk1("idle_ready", word_ready, 1'b0);
        chk1("idle_valid", header_valid, 1'b0);
        chkw("idle_c1", chunk1, '0);
        header_ack = 1'b0; word_valid = 1'b0;

        // back-to-back load
        start = 1'b1; tick(); start = 1'b0;
        chk1("load_ready", word_ready, 1'b1);
        for (int k = 0; k < 20; k++) begin
            word_valid = 1'b1;
            word_in    = cur[k];
            tick();
            if (k < 19) chk1("t1_early_valid", header_valid, 1'b0);
        end
        word_valid = 1'b0;
        chk1("t1_valid", header_valid, 1'b1);
        chk1("t1_ready", word_ready, 1'b0);
        chkw("t1_w0", 512'(chunk1[511:480]), 512'(32'h01000000));
        chkw("t1_nonce", 512'(chunk2[31:0]), 512'(32'h0f2b5710));
        chkw("t1_c1", chunk1, exp1());
        chkw("t1_c2", 512'(chunk2), exp2());
        word_valid = 1'b1; word_in = 32'h12345678;
`ifndef PD_NONCE_INC_EN
        start = 1'b1;
`endif
        tick(); tick();
        word_valid = 1'b0; start = 1'b0;
        chk1("hold_valid", header_valid, 1'b1);
        chkw("hold_c1", chunk1, exp1());
        chkw("hold_c2", 512'(chunk2), exp2());
`ifdef PD_NONCE_INC_EN
        header_ack = 1'b1; tick(); header_ack = 1'b0;
        chk1("bump_valid", header_valid, 1'b0);
        chkw("bump_old", 512'(chunk2[31:0]), 512'(32'h0f2b5710));
        tick();
        chk1("bumped_valid", header_valid, 1'b1);
        chkw("bumped_nonce", 512'(chunk2[31:0]), 512'(32'h102b5710));
        chkw("bumped_c1", chunk1, exp1());
        chk1("bumped_wrap", nonce_wrap, 1'b0);
`else
        header_ack = 1'b1; tick(); header_ack = 1'b0;
        chk1("ack_valid", header_valid, 1'b0);
        chk1("ack_ready", word_ready, 1'b0);
        chkw("ack_c1", chunk1, exp1());
        chkw("ack_c2", 512'(chunk2), exp2());
        chk1("ack_wrap", nonce_wrap, 1'b0);
`endif

        // gapped load
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            word_valid = 1'b1;
            word_in    = cur[k];
            tick();
            word_valid = 1'b0;
            if (k < 19)
                repeat ((k % 2 == 1) ? 3 : 1) begin
                    tick();
                    chk1("t2_valid", header_valid, 1'b0);
                    chk1("t2_tmo", timeout_err, 1'b0);
                end
        end
        chk1("t2_done_valid", header_valid, 1'b1);
        chkw("t2_c1", chunk1, exp1());
        chkw("t2_c2", 512'(chunk2), exp2());
`ifndef PD_NONCE_INC_EN
        header_ack = 1'b1;
`endif
        start = 1'b1; tick(); start = 1'b0; header_ack = 1'b0;
        chk1("reload_ready", word_ready, 1'b1);
        chk1("reload_valid", header_valid, 1'b0);
        chkw("reload_c1", chunk1, '0);

        // inter-word timeout after 5 words
        feed(5);
        repeat (7) begin
            tick();
            chk1("t3_no_tmo", timeout_err, 1'b0);
            chk1("t3_ready", word_ready, 1'b1);
        end
        chkw("t3_partial_w0", 512'(chunk1[511:480]), 512'(cur[0]));
        tick();
        chk1("t3_tmo", timeout_err, 1'b1);
        chk1("t3_ready_off", word_ready, 1'b0);
        chkw("t3_c1", chunk1, '0);
        chkw("t3_c2", 512'(chunk2), '0);
        tick();
        chk1("t3_tmo_pulse", timeout_err, 1'b0);

        // restart mid-load, start beats a simultaneous word
        start = 1'b1; tick(); start = 1'b0;
        feed(10);
        start = 1'b1; word_valid = 1'b1; word_in = 32'hcafef00d;
        tick();
        start = 1'b0; word_valid = 1'b0;
        chkw("t4_clr_c1", chunk1, '0);
        chk1("t4_ready", word_ready, 1'b1);
        for (int k = 0; k < 20; k++) cur[k] = ~cur[k];
        for (int k = 0; k < 20; k++) begin
            word_valid = 1'b1;
            word_in    = cur[k];
            tick();
            if (k < 19) chk1("t4_early_valid", header_valid, 1'b0);
        end
        word_valid = 1'b0;
        chk1("t4_valid", header_valid, 1'b1);
        chkw("t4_c1", chunk1, exp1());
        chkw("t4_c2", 512'(chunk2), exp2());
        header_ack = 1'b1; tick(); header_ack = 1'b0;
        chk1("t4_ack_valid", header_valid, 1'b0);
`ifndef PD_NONCE_INC_EN
        chkw("t4_ack_c1", chunk1, exp1());
`endif

        // asynchronous reset mid-load and in hold
        start = 1'b1; tick(); start = 1'b0;
        feed(7);
        n_rst = 1'b0; #1;
        chk1("t5_load_ready", word_ready, 1'b0);
        chkw("t5_load_c1", chunk1, '0);
        tick(); n_rst = 1'b1; tick();
        start = 1'b1; tick(); start = 1'b0;
        feed(20);
        chk1("t5_hold_pre", header_valid, 1'b1);
        n_rst = 1'b0; #1;
        chk1("t5_hold_valid", header_valid, 1'b0);
        chkw("t5_hold_c1", chunk1, '0);
        chkw("t5_hold_c2", 512'(chunk2), '0);
        n_rst = 1'b1; tick();

`ifdef PD_NONCE_INC_EN
        // nonce 0xffffffff wraps to zero and releases to idle
        base_hdr();
        cur[19] = 32'hffffffff;
        start = 1'b1; tick(); start = 1'b0;
        feed(20);
        header_ack = 1'b1; tick(); header_ack = 1'b0;
        chk1("t6_bump_valid", header_valid, 1'b0);
        tick();
        chkw("t6_nonce", 512'(chunk2[31:0]), '0);
        chk1("t6_wrap", nonce_wrap, 1'b1);
        chk1("t6_valid", header_valid, 1'b0);
        chk1("t6_ready", word_ready, 1'b0);
        tick();
        chk1("t6_wrap_pulse", nonce_wrap, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
